ssem_sequencer: RTL and testbench

- Parametrised, synchronous successor to the fixed 40-bit reduced machine.
- Executes the same 11-instruction set from an internal line store, with configurable word width and store depth.
- Adds run/single-step/halt control, a manual store-write port for halted loading, and an executed-instruction counter.
- Its outputs drive the display and oscilloscope taps directly; it replaces the controller/timing/staticisor chain with one explicit FSM.

---
 rtl/ssem_sequencer_if.sv | 32 +++
 rtl/ssem_sequencer.sv | 161 ++++++++++++++++
 tb/tb_ssem_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssem_sequencer_if.sv
// Operator-panel bundle for ssem_sequencer: run/step/stop keys, manual
// store loading, display read port and the oscilloscope/display taps.
interface ssem_sequencer_if #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_BITS   = 5,
  parameter int CNT_BITS    = 16
) ();
  logic                   w_KSP;
  logic                   w_KSS;
  logic                   w_KST;
  logic                   w_MW_EN;
  logic [ADDR_BITS-1:0]   b_MW_ADDR;
  logic [WORD_LENGTH-1:0] b_MW_DATA;
  logic [ADDR_BITS-1:0]   b_RD_ADDR;
  logic [WORD_LENGTH-1:0] b_RD_DATA;
  logic [WORD_LENGTH-1:0] b_A;
  logic [ADDR_BITS-1:0]   b_CI;
  logic [WORD_LENGTH-1:0] b_PI;
  logic                   w_SL;
  logic [1:0]             b_STATE;
  logic [CNT_BITS-1:0]    b_COUNT;

  modport slave (
    input  w_KSP, w_KSS, w_KST, w_MW_EN, b_MW_ADDR, b_MW_DATA, b_RD_ADDR,
    output b_RD_DATA, b_A, b_CI, b_PI, w_SL, b_STATE, b_COUNT
  );

  modport master (
    output w_KSP, w_KSS, w_KST, w_MW_EN, b_MW_ADDR, b_MW_DATA, b_RD_ADDR,
    input  b_RD_DATA, b_A, b_CI, b_PI, w_SL, b_STATE, b_COUNT
  );
endinterface

// File: rtl/ssem_sequencer.sv
// Parametrised SSEM-style sequencer: line store, accumulator, CI/PI and a
// single HALT/SCAN/FETCH/EXEC FSM replacing the old timing chain.
//
// state | meaning
// HALT  | stopped, stop lamp lit, manual store writes accepted
// SCAN  | CI <= CI + 1
// FETCH | PI <= store[CI]
// EXEC  | execute PI, bump instruction count, then SCAN or HALT
module ssem_sequencer #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_BITS   = 5,
  parameter int FUNC_BITS   = 6,
  parameter int CNT_BITS    = 16
) (
  input  logic w_CLK,
  input  logic w_RST,
  ssem_sequencer_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;

  localparam logic [FUNC_BITS-1:0] INST_NOP = FUNC_BITS'(6'b000000);
  localparam logic [FUNC_BITS-1:0] INST_CMP = FUNC_BITS'(6'b000101);
  localparam logic [FUNC_BITS-1:0] INST_JMP = FUNC_BITS'(6'b001101);
  localparam logic [FUNC_BITS-1:0] INST_STA = FUNC_BITS'(6'b010100);
  localparam logic [FUNC_BITS-1:0] INST_LDA = FUNC_BITS'(6'b100000);
  localparam logic [FUNC_BITS-1:0] INST_Z   = FUNC_BITS'(6'b100100);
  localparam logic [FUNC_BITS-1:0] INST_ADD = FUNC_BITS'(6'b101100);
  localparam logic [FUNC_BITS-1:0] INST_SUB = FUNC_BITS'(6'b100110);
  localparam logic [FUNC_BITS-1:0] INST_NEG = FUNC_BITS'(6'b110110);
  localparam logic [FUNC_BITS-1:0] INST_SHR = FUNC_BITS'(6'b111110);
  localparam logic [FUNC_BITS-1:0] INST_HLT = FUNC_BITS'(6'b111111);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_SCAN  = 2'b01,
    ST_FETCH = 2'b10,
    ST_EXEC  = 2'b11
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_LENGTH-1:0] store [DEPTH];
  logic [WORD_LENGTH-1:0] acc_q, acc_d;
  logic [ADDR_BITS-1:0]   ci_q, ci_d;
  logic [WORD_LENGTH-1:0] pi_q, pi_d;
  logic [CNT_BITS-1:0]    count_q, count_d;
  logic                   run_q, run_d;
  logic                   ksp_prev_q;
  logic                   need_edge_q, need_edge_d;

  logic                   st_we;
  logic [ADDR_BITS-1:0]   st_addr;
  logic [WORD_LENGTH-1:0] st_data;

  logic [FUNC_BITS-1:0]   func;
  logic [ADDR_BITS-1:0]   op_addr;
  logic [WORD_LENGTH-1:0] operand;
  logic                   ksp_ok;

  assign func    = pi_q[WORD_LENGTH-1 -: FUNC_BITS];
  assign op_addr = pi_q[ADDR_BITS-1:0];
  assign operand = store[op_addr];

  // After a HLT, a held run key must be released and pressed again.
  assign ksp_ok = bus.w_KSP && (!need_edge_q || !ksp_prev_q);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ci_d        = ci_q;
    pi_d        = pi_q;
    count_d     = count_q;
    run_d       = run_q;
    need_edge_d = need_edge_q;
    st_we       = 1'b0;
    st_addr     = '0;
    st_data     = '0;
    case (state_q)
      ST_HALT: begin
        if (bus.w_MW_EN) begin
          st_we   = 1'b1;
          st_addr = bus.b_MW_ADDR;
          st_data = bus.b_MW_DATA;
        end
        if (ksp_ok) begin
          state_d     = ST_SCAN;
          run_d       = 1'b1;
          need_edge_d = 1'b0;
        end else if (bus.w_KSS) begin
          state_d = ST_SCAN;
          run_d   = 1'b0;
        end
      end
      ST_SCAN: begin
        ci_d    = ci_q + ADDR_BITS'(1);
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        pi_d    = store[ci_q];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        count_d = count_q + CNT_BITS'(1);
        case (func)
          INST_LDA: acc_d = operand;
          INST_ADD: acc_d = acc_q + operand;
          INST_SUB: acc_d = acc_q - operand;
          INST_NEG: acc_d = -operand;
          INST_Z:   acc_d = '0;
          INST_SHR: acc_d = {acc_q[WORD_LENGTH-1], acc_q[WORD_LENGTH-1:1]};
          INST_STA: begin
            st_we   = 1'b1;
            st_addr = op_addr;
            st_data = acc_q;
          end
          INST_JMP: ci_d = operand[ADDR_BITS-1:0];
          INST_CMP: if (acc_q[WORD_LENGTH-1]) ci_d = ci_q + ADDR_BITS'(1);
          INST_HLT: need_edge_d = 1'b1;
          INST_NOP: ;
          default:  ;
        endcase
        if (func == INST_HLT || !run_q || bus.w_KST) state_d = ST_HALT;
        else                                         state_d = ST_SCAN;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge w_CLK) begin
    ksp_prev_q <= bus.w_KSP;
    if (w_RST) begin
      state_q     <= ST_HALT;
      acc_q       <= '0;
      ci_q        <= '0;
      pi_q        <= '0;
      count_q     <= '0;
      run_q       <= 1'b0;
      need_edge_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ci_q        <= ci_d;
      pi_q        <= pi_d;
      count_q     <= count_d;
      run_q       <= run_d;
      need_edge_q <= need_edge_d;
    end
  end

  // Store survives reset; reset only blocks a write in the same cycle.
  always_ff @(posedge w_CLK) begin
    if (st_we && !w_RST) store[st_addr] <= st_data;
  end

  assign bus.b_RD_DATA = store[bus.b_RD_ADDR];
  assign bus.b_A       = acc_q;
  assign bus.b_CI      = ci_q;
  assign bus.b_PI      = pi_q;
  assign bus.w_SL      = (state_q == ST_HALT);
  assign bus.b_STATE   = state_q;
  assign bus.b_COUNT   = count_q;
endmodule

// File: tb/tb_ssem_sequencer.sv
// Scoreboard bench: stimulus runs a behavioural SSEM model and queues the
// expected halt snapshot; a monitor compares on every entry into HALT.
module tb_ssem_sequencer;
  localparam int W = 32;
  localparam int AB = 5;
  localparam int CB = 16;
  localparam int DEPTH = 32;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_CMP = 6'b000101;
  localparam logic [5:0] OP_JMP = 6'b001101;
  localparam logic [5:0] OP_STA = 6'b010100;
  localparam logic [5:0] OP_LDA = 6'b100000;
  localparam logic [5:0] OP_Z   = 6'b100100;
  localparam logic [5:0] OP_ADD = 6'b101100;
  localparam logic [5:0] OP_SUB = 6'b100110;
  localparam logic [5:0] OP_NEG = 6'b110110;
  localparam logic [5:0] OP_SHR = 6'b111110;
  localparam logic [5:0] OP_HLT = 6'b111111;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ssem_sequencer_if #(.WORD_LENGTH(W), .ADDR_BITS(AB), .CNT_BITS(CB)) bus ();

  ssem_sequencer #(.WORD_LENGTH(W), .ADDR_BITS(AB), .FUNC_BITS(6), .CNT_BITS(CB)) dut (
    .w_CLK(clk),
    .w_RST(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input int id, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", name, id, act, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [4:0]  ci;
    logic [31:0] pi;
    logic [15:0] count;
    int          cycles;
    logic [31:0] rd;
  } exp_t;

  exp_t sbq[$];

  // Reference machine state
  logic [31:0] mem [DEPTH];
  logic [31:0] m_a;
  logic [31:0] m_pi;
  logic [4:0]  m_ci;
  logic [15:0] m_count;
  int          run_start = 0;
  logic [4:0]  chk_addr = '0;
  bit          mon_en = 1'b0;
  bit          sl_prev = 1'b1;

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] ad);
    return {op, 21'd0, ad};
  endfunction

  task automatic model_run(input int max_instr, output int n);
    logic [5:0]  op;
    logic [31:0] s;
    n = 0;
    while (1) begin
      m_ci = m_ci + 5'd1;
      m_pi = mem[m_ci];
      op = m_pi[31:26];
      s = mem[m_pi[4:0]];
      m_count = m_count + 16'd1;
      n++;
      case (op)
        OP_LDA: m_a = s;
        OP_ADD: m_a = m_a + s;
        OP_SUB: m_a = m_a - s;
        OP_NEG: m_a = -s;
        OP_Z:   m_a = 32'd0;
        OP_SHR: m_a = 32'($signed(m_a) >>> 1);
        OP_STA: mem[m_pi[4:0]] = m_a;
        OP_JMP: m_ci = s[4:0];
        OP_CMP: if ($signed(m_a) < 0) m_ci = m_ci + 5'd1;
        default: ;
      endcase
      if (op == OP_HLT || n >= max_instr) break;
    end
  endtask

  task automatic push_expect(input int id, input int n);
    exp_t e;
    e.id = id; e.a = m_a; e.ci = m_ci; e.pi = m_pi; e.count = m_count;
    e.cycles = 3 * n; e.rd = mem[chk_addr];
    sbq.push_back(e);
  endtask

  task automatic mwrite(input logic [4:0] ad, input logic [31:0] d);
    @(negedge clk);
    bus.w_MW_EN = 1'b1; bus.b_MW_ADDR = ad; bus.b_MW_DATA = d;
    mem[ad] = d;
    @(negedge clk);
    bus.w_MW_EN = 1'b0;
  endtask

  task automatic set_chk(input logic [4:0] ad);
    chk_addr = ad;
    bus.b_RD_ADDR = ad;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_a = '0; m_ci = '0; m_pi = '0; m_count = '0;
  endtask

  task automatic wait_halt(input int id);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.w_SL) return;
    end
    checks++; failures++;
    $display("FAIL halt_timeout[%0d] actual=running required=halted", id);
  endtask

  task automatic go(input int id, input bit step, input int max_instr, input bit hold);
    int n;
    model_run(max_instr, n);
    push_expect(id, n);
    @(negedge clk);
    if (step) bus.w_KSS = 1'b1; else bus.w_KSP = 1'b1;
    @(negedge clk);
    run_start = cyc;
    bus.w_KSS = 1'b0;
    if (!hold) bus.w_KSP = 1'b0;
    wait_halt(id);
  endtask

  // Monitor: every entry into HALT is one scoreboard transaction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && bus.w_SL && !sl_prev) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_halt[0] actual=halt required=no_halt");
        end else begin
          e = sbq.pop_front();
          check(e.id, "acc",    bus.b_A,       e.a);
          check(e.id, "ci",     bus.b_CI,      e.ci);
          check(e.id, "pi",     bus.b_PI,      e.pi);
          check(e.id, "count",  bus.b_COUNT,   e.count);
          check(e.id, "cycles", cyc - run_start, e.cycles);
          check(e.id, "store",  bus.b_RD_DATA, e.rd);
          check(e.id, "state",  bus.b_STATE,   2'b00);
        end
      end
      sl_prev = bus.w_SL;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog[0] actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [5:0] rops [10];

  initial begin
    int n;
    rops = '{OP_NOP, OP_CMP, OP_STA, OP_LDA, OP_Z, OP_ADD, OP_SUB, OP_NEG, OP_SHR, 6'b000001};
    bus.w_KSP = 0; bus.w_KSS = 0; bus.w_KST = 0; bus.w_MW_EN = 0;
    bus.b_MW_ADDR = '0; bus.b_MW_DATA = '0; bus.b_RD_ADDR = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    m_a = '0; m_ci = '0; m_pi = '0; m_count = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check(0, "rst_acc",   bus.b_A,     0);
    check(0, "rst_ci",    bus.b_CI,    0);
    check(0, "rst_pi",    bus.b_PI,    0);
    check(0, "rst_count", bus.b_COUNT, 0);
    check(0, "rst_state", bus.b_STATE, 0);
    check(0, "rst_sl",    bus.w_SL,    1);
    mon_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) mwrite(5'(i), 32'd0);

    // Manual-load program: 7 - 9 stored at line 12
    mwrite(1, ins(OP_LDA, 10)); mwrite(2, ins(OP_SUB, 11));
    mwrite(3, ins(OP_STA, 12)); mwrite(4, ins(OP_HLT, 0));
    mwrite(10, 32'd7); mwrite(11, 32'd9);
    mwrite(5, ins(OP_HLT, 0)); mwrite(6, ins(OP_HLT, 0));
    set_chk(12);
    go(1, 0, 64, 0);

    // Run key held through HLT must not restart until released
    go(2, 0, 64, 1);
    repeat (6) @(negedge clk);
    check(2, "held_sl", bus.w_SL, 1);
    check(2, "held_ci", bus.b_CI, 5);
    bus.w_KSP = 1'b0;
    go(3, 0, 64, 0);

    // CMP skip with negative and positive accumulator
    for (int k = 0; k < 2; k++) begin
      do_reset();
      mwrite(1, ins(OP_LDA, 20)); mwrite(2, ins(OP_CMP, 0));
      mwrite(3, ins(OP_HLT, 0));  mwrite(4, ins(OP_HLT, 0));
      mwrite(20, (k == 0) ? 32'hFFFF_FFFF : 32'd1);
      set_chk(20);
      go(10 + k, 0, 64, 0);
    end

    // JMP via store word, then CI wrap 31 -> 0
    do_reset();
    mwrite(1, ins(OP_JMP, 20)); mwrite(20, 32'd7); mwrite(8, ins(OP_HLT, 0));
    mwrite(9, ins(OP_JMP, 21)); mwrite(21, 32'd30);
    mwrite(31, ins(OP_NOP, 0)); mwrite(0, ins(OP_HLT, 0));
    set_chk(21);
    go(20, 0, 64, 0);
    go(21, 0, 64, 0);

    // Overflow and arithmetic shift
    do_reset();
    mwrite(1, ins(OP_LDA, 20)); mwrite(2, ins(OP_ADD, 21)); mwrite(3, ins(OP_STA, 22));
    mwrite(4, ins(OP_SHR, 0));  mwrite(5, ins(OP_HLT, 0));
    mwrite(6, ins(OP_ADD, 21)); mwrite(7, ins(OP_NEG, 21));
    mwrite(20, 32'h7FFF_FFFF); mwrite(21, 32'd1); mwrite(22, 32'd0);
    set_chk(22);
    go(30, 0, 64, 0);

    // Single step; a manual write during SCAN must be dropped
    model_run(1, n);
    push_expect(31, n);
    @(negedge clk); bus.w_KSS = 1'b1;
    @(negedge clk); run_start = cyc; bus.w_KSS = 1'b0;
    bus.w_MW_EN = 1'b1; bus.b_MW_ADDR = 22; bus.b_MW_DATA = 32'h0000_1234;
    @(negedge clk); bus.w_MW_EN = 1'b0;
    wait_halt(31);

    // Stop key held: run stops after one instruction
    bus.w_KST = 1'b1;
    go(32, 0, 1, 0);
    bus.w_KST = 1'b0;

    // Reset in EXEC of ADD with A=5
    do_reset();
    mwrite(1, ins(OP_LDA, 20)); mwrite(2, ins(OP_ADD, 21)); mwrite(3, ins(OP_HLT, 0));
    mwrite(20, 32'd5); mwrite(21, 32'd3);
    set_chk(21);
    @(negedge clk); bus.w_KSP = 1'b1;
    @(negedge clk); run_start = cyc; bus.w_KSP = 1'b0;
    repeat (5) @(negedge clk);
    check(40, "pre_rst_state", bus.b_STATE, 2'b11);
    check(40, "pre_rst_acc",   bus.b_A,     5);
    m_a = '0; m_ci = '0; m_pi = '0; m_count = '0;
    push_expect(40, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Randomised straight-line programs with data region 20..31
    for (int t = 0; t < 25; t++) begin
      do_reset();
      for (int l = 1; l < 16; l++)
        mwrite(5'(l), ins(rops[$urandom_range(0, 9)], 5'($urandom_range(20, 31))));
      for (int l = 16; l < 20; l++) mwrite(5'(l), ins(OP_HLT, 0));
      for (int l = 20; l < 32; l++) begin
        case ($urandom_range(0, 4))
          0: mwrite(5'(l), 32'h7FFF_FFFF);
          1: mwrite(5'(l), 32'h8000_0000);
          2: mwrite(5'(l), 32'($urandom_range(0, 15)));
          default: mwrite(5'(l), $urandom);
        endcase
      end
      set_chk(5'($urandom_range(20, 31)));
      go(100 + t, 0, 64, 0);
    end

    repeat (4) @(negedge clk);
    check(999, "sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
